// File: rtl/l1_cache_arbiter.sv
// l1_cache_arbiter: shares one single-ported L1 cache between fetch (p0) and load/store (p1).
// Define ROUND_ROBIN_EN for round-robin tie-break; otherwise p1 has fixed priority.
module l1_cache_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_grant;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_sel;
    logic              w_last;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

`ifdef ROUND_ROBIN_EN
    // r_rr names the port that wins the next tie
    logic r_rr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_accept) begin
            r_rr <= ~w_sel;
        end
    end

    assign w_sel = p1_req_valid & (~p0_req_valid | r_rr);
`else
    assign w_sel = p1_req_valid;
`endif

    assign w_we    = w_sel ? p1_req_we    : p0_req_we;
    assign w_addr  = w_sel ? p1_req_addr  : p0_req_addr;
    assign w_wdata = w_sel ? p1_req_wdata : p0_req_wdata;
    assign w_last  = (r_cnt == '0);

    assign p0_req_ready = w_accept & ~w_sel;
    assign p1_req_ready = w_accept & w_sel;
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // no grant while reset is asserted
                if (!rst && (p0_req_valid || p1_req_valid)) begin
                    w_accept = 1'b1;
                    w_next   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_last) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant          <= 1'b0;
            r_we             <= 1'b0;
            r_cnt            <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            p0_resp_valid    <= 1'b0;
            p0_resp_rdata    <= '0;
            p1_resp_valid    <= 1'b0;
            p1_resp_rdata    <= '0;
        end else begin
            p0_resp_valid <= 1'b0;
            p1_resp_valid <= 1'b0;
            if (w_accept) begin
                r_grant          <= w_sel;
                r_we             <= w_we;
                r_cnt            <= CNT_INIT;
                mem_address      <= w_addr;
                mem_write_data   <= w_wdata;
                mem_write_enable <= w_we;
                mem_read_enable  <= ~w_we;
            end else if (r_state == S_ACCESS) begin
                if (w_last) begin
                    mem_address      <= '0;
                    mem_write_data   <= '0;
                    mem_write_enable <= 1'b0;
                    mem_read_enable  <= 1'b0;
                    if (r_grant) begin
                        p1_resp_valid <= 1'b1;
                        p1_resp_rdata <= r_we ? '0 : mem_read_data;
                    end else begin
                        p0_resp_valid <= 1'b1;
                        p0_resp_rdata <= r_we ? '0 : mem_read_data;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_cache_arbiter.sv
// tb_l1_cache_arbiter: directed tables plus random traffic against a transaction-level model.
// A second instance with MEM_LATENCY=3 covers long accesses and mid-access reset.
module tb_l1_cache_arbiter;

    localparam int L  = 1;
    localparam int L3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic        p0_req_valid, p0_req_ready, p0_req_we, p0_resp_valid;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_resp_valid;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable, busy;

    logic        q0_req_valid, q0_req_ready, q0_req_we, q0_resp_valid;
    logic [31:0] q0_req_addr, q0_req_wdata, q0_resp_rdata;
    logic        q1_req_valid, q1_req_ready, q1_req_we, q1_resp_valid;
    logic [31:0] q1_req_addr, q1_req_wdata, q1_resp_rdata;
    logic [31:0] qmem_address, qmem_write_data, qmem_read_data;
    logic        qmem_write_enable, qmem_read_enable, qbusy;

    l1_cache_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid),
        .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid),
        .p1_resp_rdata(p1_resp_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    l1_cache_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L3)) dut3 (
        .clk(clk), .rst(rst3),
        .p0_req_valid(q0_req_valid), .p0_req_ready(q0_req_ready),
        .p0_req_we(q0_req_we), .p0_req_addr(q0_req_addr),
        .p0_req_wdata(q0_req_wdata), .p0_resp_valid(q0_resp_valid),
        .p0_resp_rdata(q0_resp_rdata),
        .p1_req_valid(q1_req_valid), .p1_req_ready(q1_req_ready),
        .p1_req_we(q1_req_we), .p1_req_addr(q1_req_addr),
        .p1_req_wdata(q1_req_wdata), .p1_resp_valid(q1_resp_valid),
        .p1_resp_rdata(q1_resp_rdata),
        .mem_address(qmem_address), .mem_write_data(qmem_write_data),
        .mem_write_enable(qmem_write_enable), .mem_read_enable(qmem_read_enable),
        .mem_read_data(qmem_read_data), .busy(qbusy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [3:0] i);
        return {16'hC0DE, 12'h000, i};
    endfunction

    // cache environments: unwritten words read as init_val, bus garbage when not enabled
    logic [31:0] env_mem[16];
    bit          env_wr[16];
    logic [31:0] env3_mem[16];
    bit          env3_wr[16];
    logic [3:0]  w_idx, w_idx3;
    assign w_idx  = mem_address[5:2];
    assign w_idx3 = qmem_address[5:2];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            env_mem[w_idx] <= mem_write_data;
            env_wr[w_idx]  <= 1'b1;
        end
        if (qmem_write_enable) begin
            env3_mem[w_idx3] <= qmem_write_data;
            env3_wr[w_idx3]  <= 1'b1;
        end
    end

    assign mem_read_data  = !mem_read_enable ? 32'hBAD0BAD0 :
                            env_wr[w_idx] ? env_mem[w_idx] : init_val(w_idx);
    assign qmem_read_data = !qmem_read_enable ? 32'hBAD0BAD0 :
                            env3_wr[w_idx3] ? env3_mem[w_idx3] : init_val(w_idx3);

    // reference model: one transaction in flight, timed by cycle arithmetic
    bit          model_on = 1'b0;
    bit          acc_act  = 1'b0;
    bit          acc_port, acc_we;
    logic [31:0] acc_addr, acc_wdata, acc_rdata;
    int          acc_start = 0;
    int          next_free = 0;
    logic [31:0] exp_rd0, exp_rd1;
    logic [31:0] ref_mem[16];
    bit          ref_wr[16];
    bit          pend = 1'b0;
    bit          pend_port, pend_we;
    logic [31:0] pend_addr, pend_wdata;
`ifdef ROUND_ROBIN_EN
    bit          pref = 1'b0;
`endif

    always @(posedge clk) begin
        int c;
        logic [3:0] i;
        c = cyc + 1;
        i = pend_addr[5:2];
        cyc <= c;
        if (rst) begin
            model_on  <= 1'b1;
            acc_act   <= 1'b0;
            next_free <= c;
            exp_rd0   <= '0;
            exp_rd1   <= '0;
`ifdef ROUND_ROBIN_EN
            pref      <= 1'b0;
`endif
        end else if (pend) begin
            acc_act   <= 1'b1;
            acc_start <= c;
            acc_port  <= pend_port;
            acc_we    <= pend_we;
            acc_addr  <= pend_addr;
            acc_wdata <= pend_wdata;
            acc_rdata <= pend_we ? 32'h0 : (ref_wr[i] ? ref_mem[i] : init_val(i));
            if (pend_we) begin
                ref_mem[i] <= pend_wdata;
                ref_wr[i]  <= 1'b1;
            end
            next_free <= c + L + 1;
`ifdef ROUND_ROBIN_EN
            pref      <= ~pend_port;
`endif
        end else if (acc_act && c == acc_start + L) begin
            if (acc_port) exp_rd1 <= acc_we ? 32'h0 : acc_rdata;
            else          exp_rd0 <= acc_we ? 32'h0 : acc_rdata;
        end
    end

    always @(negedge clk) begin
        bit e0, e1, win, tie, ia, ir;
        if (model_on) begin
            e0 = 1'b0;
            e1 = 1'b0;
`ifdef ROUND_ROBIN_EN
            tie = pref;
`else
            tie = 1'b1;
`endif
            if (!rst && cyc >= next_free && (p0_req_valid || p1_req_valid)) begin
                win = (p0_req_valid && p1_req_valid) ? tie : p1_req_valid;
                e0 = ~win;
                e1 = win;
                pend       <= 1'b1;
                pend_port  <= win;
                pend_we    <= win ? p1_req_we : p0_req_we;
                pend_addr  <= win ? p1_req_addr : p0_req_addr;
                pend_wdata <= win ? p1_req_wdata : p0_req_wdata;
            end else begin
                pend <= 1'b0;
            end
            ia = acc_act && cyc >= acc_start && cyc < acc_start + L;
            ir = acc_act && cyc == acc_start + L;
            chk("p0_ready", 32'(p0_req_ready), 32'(e0));
            chk("p1_ready", 32'(p1_req_ready), 32'(e1));
            chk("mem_we", 32'(mem_write_enable), 32'(ia & acc_we));
            chk("mem_re", 32'(mem_read_enable), 32'(ia & ~acc_we));
            chk("mem_addr", mem_address, ia ? acc_addr : 32'h0);
            chk("mem_wdata", mem_write_data, ia ? acc_wdata : 32'h0);
            chk("busy", 32'(busy), 32'(ia | ir));
            chk("p0_rv", 32'(p0_resp_valid), 32'(ir & ~acc_port));
            chk("p1_rv", 32'(p1_resp_valid), 32'(ir & acc_port));
            chk("p0_rdata", p0_resp_rdata, exp_rd0);
            chk("p1_rdata", p1_resp_rdata, exp_rd1);
            chk("en_excl", 32'(mem_write_enable & mem_read_enable), 32'h0);
            chk("q_en_excl", 32'(qmem_write_enable & qmem_read_enable), 32'h0);
            chk("q_rv_excl", 32'(q0_resp_valid & q1_resp_valid), 32'h0);
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic drive(input bit port, input bit v, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
        end else begin
            p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
        end
    endtask

    task automatic do_txn(input vec_t t);
        bit got;
        bit we_seen;
        int lat;
        @(posedge clk); #1;
        drive(t.port, 1'b1, t.we, t.addr, t.wdata);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = t.port ? p1_req_ready : p0_req_ready;
        end
        chk("txn_accept", 32'(got), 32'h1);
        @(posedge clk); #1;
        drive(t.port, 1'b0, 1'b0, 32'h0, 32'h0);
        if (!got) return;
        lat = 0;
        got = 1'b0;
        we_seen = 1'b0;
        while (!got && lat < 10) begin
            lat++;
            @(negedge clk);
            if (lat == 1) we_seen = mem_write_enable;
            got = t.port ? p1_resp_valid : p0_resp_valid;
        end
        chk("txn_lat", 32'(lat), 32'(L + 1));
        chk("txn_we", 32'(we_seen), 32'(t.we));
        chk("txn_rdata", t.port ? p1_resp_rdata : p0_resp_rdata, t.exp_rdata);
    endtask

    task automatic do_read3(input logic [31:0] a, input logic [31:0] exp);
        bit got;
        int re_cnt, resp_k, resp_n;
        bit we_seen;
        @(posedge clk); #1;
        q0_req_valid = 1'b1; q0_req_we = 1'b0; q0_req_addr = a; q0_req_wdata = 32'h0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = q0_req_ready;
        end
        chk("q_accept", 32'(got), 32'h1);
        @(posedge clk); #1;
        q0_req_valid = 1'b0;
        re_cnt = 0; resp_k = 0; resp_n = 0; we_seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) chk("q_addr", qmem_address, a);
            if (qmem_read_enable) re_cnt++;
            if (qmem_write_enable) we_seen = 1'b1;
            if (q0_resp_valid) begin
                resp_n++;
                if (resp_k == 0) resp_k = k;
            end
        end
        chk("q_re_cycles", 32'(re_cnt), 32'(L3));
        chk("q_resp_edge", 32'(resp_k), 32'(L3 + 1));
        chk("q_resp_count", 32'(resp_n), 32'h1);
        chk("q_we_never", 32'(we_seen), 32'h0);
        chk("q_rdata", q0_resp_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        bit   exp_g[4];
        bit   g;
        bit   got;
        bit   r0, r1;
        int   last_c;
        int   rv_cnt;

        vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h14, 32'h0,        32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 32'h14, 32'h0,        32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
`ifdef ROUND_ROBIN_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        // T1: reset held three edges with both valids up
        rst = 1'b1; rst3 = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
        q0_req_valid = 1'b0; q0_req_we = 1'b0; q0_req_addr = 32'h0; q0_req_wdata = 32'h0;
        q1_req_valid = 1'b0; q1_req_we = 1'b0; q1_req_addr = 32'h0; q1_req_wdata = 32'h0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'({p0_req_ready, p1_req_ready}), 32'h0);
            chk("rst_busy", 32'({busy, qbusy}), 32'h0);
            chk("rst_mem", 32'({mem_write_enable, mem_read_enable}), 32'h0);
            chk("rst_rv", 32'({p0_resp_valid, p1_resp_valid}), 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0; rst3 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // T2: directed write/read table
        foreach (vecs[i]) do_txn(vecs[i]);

        // T3/T4: continuous tie
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
        last_c = 0;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            g = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                got = p0_req_ready | p1_req_ready;
                g = p1_req_ready;
            end
            chk("tie_accept", 32'(got), 32'h1);
            chk("tie_grant", 32'(g), 32'(exp_g[n]));
            if (n > 0) chk("tie_spacing", 32'(cyc - last_c), 32'(L + 2));
            last_c = cyc;
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);

        // random traffic, model-checked every cycle
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r0 = p0_req_ready;
            r1 = p1_req_ready;
            @(posedge clk); #1;
            if (p0_req_valid && r0) p0_req_valid = 1'b0;
            if (p1_req_valid && r1) p1_req_valid = 1'b0;
            if (!p0_req_valid && $urandom_range(0, 2) == 0)
                drive(1'b0, 1'b1, 1'($urandom_range(0, 1)),
                      {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
            if (!p1_req_valid && $urandom_range(0, 2) == 0)
                drive(1'b1, 1'b1, 1'($urandom_range(0, 1)),
                      {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
        end
        @(negedge clk);
        r0 = p0_req_ready;
        r1 = p1_req_ready;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(posedge clk);

        // T5: long-latency read
        do_read3(32'h40, init_val(4'h0));

        // T6: reset during the second access cycle of a p1 write
        @(posedge clk); #1;
        q1_req_valid = 1'b1; q1_req_we = 1'b1; q1_req_addr = 32'h44; q1_req_wdata = 32'h12345678;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = q1_req_ready;
        end
        chk("t6_accept", 32'(got), 32'h1);
        @(posedge clk); #1;
        q1_req_valid = 1'b0;
        @(negedge clk);
        chk("t6_we_1st", 32'(qmem_write_enable), 32'h1);
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(negedge clk);
        chk("t6_we_2nd", 32'(qmem_write_enable), 32'h1);
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(negedge clk);
        chk("t6_en_off", 32'({qmem_write_enable, qmem_read_enable}), 32'h0);
        chk("t6_busy", 32'(qbusy), 32'h0);
        rv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (q1_resp_valid) rv_cnt++;
            @(negedge clk);
        end
        chk("t6_no_resp", 32'(rv_cnt), 32'h0);
        do_read3(32'h48, init_val(4'h2));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
